// File: rtl/reg_dump_ctrl.sv
// Register-bank dump controller: walks registers 0..NUM_REGS-1, reads each word
// and streams it MSB-first as bytes over a valid/ready transmit handshake.
module reg_dump_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic [4:0]            o_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BC_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned SH_W      = BC_W + 3;

    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic [IDX_W-1:0]      index_q,    index_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] word_q,     word_d;
    logic [IDX_W-1:0]      reg_addr_q, reg_addr_d;
    logic [7:0]            tx_data_q,  tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic                  xfer;
    logic [BC_W-1:0]       sel_byte;
    logic [SH_W-1:0]       shift_amt;
    logic [DATA_WIDTH-1:0] word_shifted;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            reg_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            reg_addr_q <= reg_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state; outputs are then registered from the next-state values so they
    // line up with the state without any path from i_tx_ready to o_tx_valid.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        xfer         = tx_valid_q & i_tx_ready;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    index_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    word_d     = i_reg_data;
                    byte_cnt_d = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end else if (index_q != LAST_IDX) begin
                        index_d = index_q + IDX_W'(1);
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            index_d    = '0;
            byte_cnt_d = '0;
        end

        sel_byte     = LAST_BYTE - byte_cnt_d;
        shift_amt    = {sel_byte, 3'b000};
        word_shifted = word_d >> shift_amt;

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        tx_valid_d = (state_d == S_SEND);
        tx_data_d  = (state_d == S_SEND) ? word_shifted[7:0] : 8'h00;
        reg_addr_d = (state_d == S_IDLE) ? '0 : index_d;
    end

    assign o_reg_addr = reg_addr_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl: a byte scoreboard filled at each dump start
// and drained on every accepted transfer.
module tb_reg_dump_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;

    logic          i_clock;
    logic          i_reset;
    logic          i_start;
    logic          i_abort;
    logic [4:0]    o_reg_addr;
    logic [DW-1:0] i_reg_data;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          o_busy;
    logic          o_done;

    logic [DW-1:0] regs [NR];
    logic [7:0]    q [$];

    int checks     = 0;
    int failures   = 0;
    int bytes_seen = 0;
    int done_total = 0;
    int wait_cnt   = 0;
    bit stall_mode = 0;

    reg_dump_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (i_reg_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    assign i_reg_data = regs[o_reg_addr];

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_dump();
        logic [DW-1:0] w;
        for (int k = 0; k < NR; k++) begin
            w = regs[k];
            for (int b = DW/8 - 1; b >= 0; b--) q.push_back(w[8*b +: 8]);
        end
    endtask

    // One clock: score the offered byte, then advance to the next falling edge.
    task automatic cyc();
        if (stall_mode) begin
            i_tx_ready = o_tx_valid && (wait_cnt >= 5);
            if (o_tx_valid && wait_cnt < 5) wait_cnt++;
        end
        if (o_tx_valid) begin
            checks++;
            assert (q.size() > 0) else begin
                failures++;
                $error("FAIL extra_byte observed=%0h expected=none", o_tx_data);
            end
            if (q.size() > 0) chk("tx_data", 32'(o_tx_data), 32'(q[0]));
            if (i_tx_ready) begin
                bytes_seen++;
                wait_cnt = 0;
                if (q.size() > 0) void'(q.pop_front());
            end
        end
        if (o_done) done_total++;
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    task automatic begin_dump();
        i_start    = 1'b1;
        bytes_seen = 0;
        push_dump();
        cyc();
        i_start = 1'b0;
        chk("start_busy", 32'(o_busy), 32'd1);
        chk("start_addr", 32'(o_reg_addr), 32'd0);
        chk("start_valid", 32'(o_tx_valid), 32'd0);
    endtask

    // Run until o_busy drops; cycle 1 is the one right after the start edge.
    task automatic run_dump(input int budget, input int pulse_at,
                            output int ncyc, output int ndone, output int done_at);
        int j;
        j = 1; ndone = 0; done_at = 0;
        while (o_busy && j <= budget) begin
            i_start = (pulse_at != 0) && (j == pulse_at || j == pulse_at + 70);
            if (o_done) begin
                ndone++;
                done_at = j;
            end
            cyc();
            j++;
        end
        i_start = 1'b0;
        ncyc = j - 1;
        chk("dump_timeout_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic full_check(input string tag, input int pulse_at, input int exp_len);
        int n, nd, da;
        run_dump(exp_len + 100, pulse_at, n, nd, da);
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
        chk({tag, "_done_cnt"}, 32'(nd), 32'd1);
        chk({tag, "_done_at"}, 32'(da), 32'(exp_len));
        chk({tag, "_bytes"}, 32'(bytes_seen), 32'(NR * DW / 8));
        chk({tag, "_q_empty"}, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_byte(input int idx);
        int n;
        n = 0;
        while (!(o_tx_valid && bytes_seen == idx) && n < 400) begin
            cyc();
            n++;
        end
        chk("reach_byte_valid", 32'(o_tx_valid), 32'd1);
        chk("reach_byte_idx", 32'(bytes_seen), 32'(idx));
    endtask

    task automatic abort_now(input string tag);
        int d0;
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        chk({tag, "_valid"}, 32'(o_tx_valid), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_addr"}, 32'(o_reg_addr), 32'd0);
        q.delete();
        d0 = done_total;
        for (int i = 0; i < 3; i++) cyc();
        chk({tag, "_no_done"}, 32'(done_total), 32'(d0));
    endtask

    initial begin
        for (int k = 0; k < NR; k++) regs[k] = 32'(k) * 32'h0101_0101;
        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_tx_ready = 1'b1;
        #2 i_reset = 1'b0;
        #2;
        chk("rst_addr", 32'(o_reg_addr), 32'd0);
        chk("rst_data", 32'(o_tx_data), 32'd0);
        chk("rst_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        cyc();

        // Plain dump at full rate
        begin_dump();
        full_check("plain", 0, 161);
        chk("plain_idle_busy", 32'(o_busy), 32'd0);
        cyc();

        // Back-pressure: five stalled cycles per byte
        regs[1] = 32'hDEAD_BEEF;
        stall_mode = 1; wait_cnt = 0;
        begin_dump();
        full_check("stall", 0, NR * (1 + 6 * DW / 8) + 1);
        stall_mode = 0; i_tx_ready = 1'b1;
        regs[1] = 32'h0101_0101;
        cyc();

        // Abort on byte 2 of register 7, then a fresh dump
        begin_dump();
        wait_byte(7 * 4 + 2);
        abort_now("abort_mid");
        begin_dump();
        full_check("after_abort", 0, 161);
        cyc();

        // Asynchronous reset between edges while in SEND
        begin_dump();
        for (int i = 0; i < 22; i++) cyc();
        chk("pre_reset_send", 32'(o_tx_valid), 32'd1);
        #2 i_reset = 1'b0;
        #1;
        chk("arst_addr", 32'(o_reg_addr), 32'd0);
        chk("arst_data", 32'(o_tx_data), 32'd0);
        chk("arst_valid", 32'(o_tx_valid), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_done", 32'(o_done), 32'd0);
        q.delete();
        @(negedge i_clock);
        i_reset = 1'b1;
        cyc();
        begin_dump();
        full_check("after_reset", 0, 161);
        cyc();

        // Abort alone in IDLE, then abort with start, plus start re-pulses mid-dump
        i_abort = 1'b1;
        cyc();
        chk("idle_abort_busy", 32'(o_busy), 32'd0);
        begin_dump();
        i_abort = 1'b0;
        full_check("ignored", 50, 161);
        cyc();

        // Abort coinciding with the final byte transfer
        begin_dump();
        wait_byte(NR * DW / 8 - 1);
        abort_now("abort_last");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register word width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, giving the number of registers dumped, indices 0..NUM_REGS-1.
REQ-003 The block SHALL have port i_clock, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_start, input, 1 bit: a dump request, sampled only in IDLE.
REQ-006 The block SHALL have port i_abort, input, 1 bit: a synchronous abort of a dump in progress.
REQ-007 The block SHALL have port o_reg_addr, output, 5 bits: the register-bank read index.
REQ-008 The block SHALL have port i_reg_data, input, DATA_WIDTH bits: the register-bank combinational read data for o_reg_addr.
REQ-009 The block SHALL have port o_tx_data, output, 8 bits: the byte offered to the transmitter.
REQ-010 The block SHALL have port o_tx_valid, output, 1 bit: o_tx_data is valid.
REQ-011 The block SHALL have port i_tx_ready, input, 1 bit: the transmitter accepts the byte.
REQ-012 The block SHALL have port o_busy, output, 1 bit: a dump is in progress, used to halt the pipeline.
REQ-013 The block SHALL have port o_done, output, 1 bit: a one-cycle pulse on dump completion.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, SEND and DONE.
REQ-015 In IDLE with i_start=1 at a rising edge, the block SHALL clear index to 0 and go to READ; o_busy SHALL be 1 from the next cycle.
REQ-016 In READ, o_reg_addr SHALL equal index, and at the edge the block SHALL latch i_reg_data into the word register, clear byte_cnt to 0 and go to SEND; READ SHALL last exactly 1 cycle.
REQ-017 In SEND, o_tx_valid SHALL be 1 and o_tx_data SHALL equal word byte (DATA_WIDTH/8-1-byte_cnt), sending MSB first.
REQ-018 A transfer SHALL occur only on an edge with o_tx_valid=1 and i_tx_ready=1; without a transfer, o_tx_data SHALL be held stable.
REQ-019 On a transfer with byte_cnt < DATA_WIDTH/8-1, byte_cnt SHALL increment and the FSM SHALL stay in SEND.
REQ-020 On a transfer of the last byte with index < NUM_REGS-1, index SHALL increment and the FSM SHALL go to READ.
REQ-021 On a transfer of the last byte with index = NUM_REGS-1, the FSM SHALL go to DONE; index SHALL NOT wrap.
REQ-022 DONE SHALL last 1 cycle with o_done=1 and o_busy=1, then the FSM SHALL go to IDLE.
REQ-023 i_start outside IDLE SHALL be ignored, so a dump cannot be restarted.
REQ-024 i_abort=1 in READ or SEND SHALL force IDLE at the next edge, with no o_done pulse and any pending byte dropped; i_abort SHALL take priority over a simultaneous transfer.
REQ-025 i_abort in IDLE or DONE SHALL have no effect.
REQ-026 The minimum dump length SHALL be NUM_REGS*(1+DATA_WIDTH/8)+1 cycles from the start edge, which is 161 cycles at the defaults with i_tx_ready held at 1.
REQ-027 Outside IDLE, o_busy SHALL be 1; outside SEND, o_tx_valid SHALL be 0.
REQ-028 o_reg_addr SHALL be 0 in IDLE.
REQ-029 All outputs SHALL be driven from registers or from the state, with no combinational path from i_tx_ready to o_tx_valid.

Reset
REQ-030 While i_reset=0, the block SHALL immediately reach and hold state IDLE with index=0, byte_cnt=0, word=0, o_reg_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0 and o_done=0.
REQ-031 Reset asserted mid-dump SHALL abandon the dump with no o_done pulse.
REQ-032 After reset is released, the first i_start SHALL begin a fresh dump at index 0.

Verification
REQ-033 Bench: regs[k]=k*0x01010101 and i_tx_ready=1, pulse i_start -> 128 bytes in order 00,00,00,00,01,01,01,01,...,1F,1F,1F,1F, one o_done pulse at cycle 161, then o_busy=0.
REQ-034 Bench: regs[1]=0xDEADBEEF, with i_tx_ready=0 for 5 cycles on each byte -> DE,AD,BE,EF each held stable while stalled, and no byte lost or duplicated.
REQ-035 Bench: i_abort during byte 2 of reg 7 -> IDLE next cycle, o_tx_valid=0, no o_done; a later i_start restarts at reg 0.
REQ-036 Bench: i_reset=0 asserted mid-SEND between clock edges -> all outputs 0 immediately; after release, i_start produces a full 128-byte dump.
REQ-037 Bench: i_start re-pulsed during the dump and i_abort pulsed in IDLE -> both ignored, and the byte stream is identical to REQ-033.
REQ-038 Bench: last byte of reg 31 transferred together with i_abort=1 -> IDLE with no o_done pulse.
